bankgroup_cmd_scheduler: RTL and testbench

- Sequences the 19-bit one-hot DDR command bus that drives one BankGroup instance.
- Arbitrates round-robin between two requesters. Each request is one closed-page access: a read or write burst to (bank, row, column).
- For each accepted request it emits ACT, waits tRCD, drives a BL-beat RD/WR burst, waits for recovery, issues PR and waits tRP before the next access.
- Sits between host-side traffic generators and the BankGroup; shares the BankGroup's `halt` input.

---
 rtl/bankgroup_cmd_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_bankgroup_cmd_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bankgroup_cmd_scheduler.sv
// bankgroup_cmd_scheduler
//
// Drives the one-hot DDR command bus of a single BankGroup. Two requesters
// are arbitrated round-robin. Each accepted request becomes one closed-page
// access: ACT, tRCD wait, BL-beat RD/WR burst, recovery (tRTP/tWR), PR, tRP.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   halt            freeze everything (shared with the BankGroup)
//   req_valid/write per-requester valid and direction (1 = write)
//   req_ba/row/col  per-requester address, requester i at [i*W +: W]
//   req_ready       combinational grant, accept on valid & ready at an edge
//   commands        one-hot bus: [18] ACT, [7] PR, [5] RD, [1] WR
//   ba/row/column   address for the current command, 0 otherwise
//   busy            access in progress (state != IDLE)
//   done            one-cycle pulse to the owner during the PR cycle
module bankgroup_cmd_scheduler #(
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned BL        = 8,
    parameter int unsigned T_RCD     = 3,
    parameter int unsigned T_RTP     = 2,
    parameter int unsigned T_WR      = 4,
    parameter int unsigned T_RP      = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     halt,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_write,
    input  logic [2*BAWIDTH-1:0]     req_ba,
    input  logic [2*ADDRWIDTH-1:0]   req_row,
    input  logic [2*COLWIDTH-1:0]    req_col,
    output logic [1:0]               req_ready,
    output logic [18:0]              commands,
    output logic [BAWIDTH-1:0]       ba,
    output logic [ADDRWIDTH-1:0]     row,
    output logic [COLWIDTH-1:0]      column,
    output logic                     busy,
    output logic [1:0]               done
);

    // Counter is wide enough for timing parameters and BL up to 255.
    localparam int unsigned CntW = 8;

    // Terminal counts for each wait state; the counter restarts at 0 on entry.
    // A state whose length would be zero is skipped entirely (Has* flags).
    localparam logic [CntW-1:0] RcdLast   = CntW'(T_RCD - 2);
    localparam logic [CntW-1:0] BurstLast = CntW'(BL - 1);
    localparam logic [CntW-1:0] RtpLast   = CntW'(T_RTP - 2);
    localparam logic [CntW-1:0] WrLast    = CntW'(T_WR - 2);
    localparam logic [CntW-1:0] RpLast    = CntW'(T_RP - 2);
    localparam bit HasRcd = (T_RCD > 1);
    localparam bit HasRtp = (T_RTP > 1);
    localparam bit HasWr  = (T_WR > 1);
    localparam bit HasRp  = (T_RP > 1);

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StRcd,
        StBurst,
        StRecov,
        StPre,
        StRp
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   owner_q, owner_d;
    logic                   rr_last_q, rr_last_d;
    logic                   wr_q, wr_d;
    logic [BAWIDTH-1:0]     ba_q, ba_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;
    logic [COLWIDTH-1:0]    col_q, col_d;
    logic                   sel;

    // Next-state, grant and request latching.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wr_d      = wr_q;
        ba_d      = ba_q;
        row_d     = row_q;
        col_d     = col_q;
        req_ready = 2'b00;
        sel       = 1'b0;

        // On a tie the requester that did not win last time is granted.
        if (state_q == StIdle && !halt) begin
            req_ready[0] = req_valid[0] && (!req_valid[1] || rr_last_q != 1'b0);
            req_ready[1] = req_valid[1] && (!req_valid[0] || rr_last_q != 1'b1);
        end

        if (!halt) begin
            case (state_q)
                StIdle: begin
                    if (|req_ready) begin
                        sel       = req_ready[1];
                        owner_d   = sel;
                        rr_last_d = sel;
                        wr_d      = req_write[sel];
                        ba_d      = sel ? req_ba[BAWIDTH +: BAWIDTH] : req_ba[0 +: BAWIDTH];
                        row_d     = sel ? req_row[ADDRWIDTH +: ADDRWIDTH]
                                        : req_row[0 +: ADDRWIDTH];
                        col_d     = sel ? req_col[COLWIDTH +: COLWIDTH] : req_col[0 +: COLWIDTH];
                        cnt_d     = '0;
                        state_d   = StAct;
                    end
                end
                StAct: begin
                    cnt_d   = '0;
                    state_d = HasRcd ? StRcd : StBurst;
                end
                StRcd: begin
                    if (cnt_q == RcdLast) begin
                        cnt_d   = '0;
                        state_d = StBurst;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StBurst: begin
                    // cnt_q is the beat index while bursting.
                    if (cnt_q == BurstLast) begin
                        cnt_d   = '0;
                        state_d = (wr_q ? HasWr : HasRtp) ? StRecov : StPre;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRecov: begin
                    if (cnt_q == (wr_q ? WrLast : RtpLast)) begin
                        cnt_d   = '0;
                        state_d = StPre;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StPre: begin
                    cnt_d   = '0;
                    state_d = HasRp ? StRp : StIdle;
                end
                StRp: begin
                    if (cnt_q == RpLast) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, so an asynchronous
    // reset clears the bus immediately and halt holds it unchanged.
    always_comb begin
        commands = '0;
        ba       = '0;
        row      = '0;
        column   = '0;
        done     = 2'b00;
        busy     = (state_q != StIdle);
        case (state_q)
            StAct: begin
                commands[18] = 1'b1;
                ba           = ba_q;
                row          = row_q;
            end
            StBurst: begin
                if (wr_q) begin
                    commands[1] = 1'b1;
                end else begin
                    commands[5] = 1'b1;
                end
                ba     = ba_q;
                row    = row_q;
                column = col_q + COLWIDTH'(cnt_q);  // wraps modulo 2^COLWIDTH
            end
            StPre: begin
                commands[7]    = 1'b1;
                ba             = ba_q;
                done[owner_q]  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wr_q      <= 1'b0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            wr_q      <= wr_d;
            ba_q      <= ba_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

endmodule

// File: tb/tb_bankgroup_cmd_scheduler.sv
// Self-checking bench for bankgroup_cmd_scheduler: a table of single
// accesses (including a halt case), hand-written sequences for round-robin
// alternation and asynchronous reset mid-burst, and a randomized phase. A
// timeline-based reference model checks every output on every cycle.
module tb_bankgroup_cmd_scheduler;

    localparam int BAW   = 2;
    localparam int AW    = 17;
    localparam int CW    = 10;
    localparam int BL    = 8;
    localparam int T_RCD = 3;
    localparam int T_RTP = 2;
    localparam int T_WR  = 4;
    localparam int T_RP  = 3;

    localparam logic [18:0] CmdAct = 19'h40000;
    localparam logic [18:0] CmdPr  = 19'h00080;
    localparam logic [18:0] CmdRd  = 19'h00020;
    localparam logic [18:0] CmdWr  = 19'h00002;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              halt      = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_write = '0;
    logic [2*BAW-1:0]  req_ba    = '0;
    logic [2*AW-1:0]   req_row   = '0;
    logic [2*CW-1:0]   req_col   = '0;
    logic [1:0]        req_ready;
    logic [18:0]       commands;
    logic [BAW-1:0]    ba;
    logic [AW-1:0]     row;
    logic [CW-1:0]     column;
    logic              busy;
    logic [1:0]        done;

    bankgroup_cmd_scheduler #(
        .BAWIDTH  (BAW),
        .ADDRWIDTH(AW),
        .COLWIDTH (CW),
        .BL       (BL),
        .T_RCD    (T_RCD),
        .T_RTP    (T_RTP),
        .T_WR     (T_WR),
        .T_RP     (T_RP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .halt     (halt),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_ba   (req_ba),
        .req_row  (req_row),
        .req_col  (req_col),
        .req_ready(req_ready),
        .commands (commands),
        .ba       (ba),
        .row      (row),
        .column   (column),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An access is a timeline measured in un-halted cycles since its ACT.
    function automatic int pr_off(input bit wr);
        return T_RCD + BL - 1 + (wr ? T_WR : T_RTP);
    endfunction

    function automatic int acc_len(input bit wr);
        return pr_off(wr) + T_RP;
    endfunction

    bit       m_active;
    int       m_t;
    bit       m_own;
    bit       m_rr;
    bit       m_wr;
    int       m_ba, m_row, m_col;
    logic [1:0] m_ready;

    always_comb begin
        m_ready = 2'b00;
        if (!m_active && !halt) begin
            m_ready[0] = req_valid[0] && (!req_valid[1] || m_rr != 1'b0);
            m_ready[1] = req_valid[1] && (!req_valid[0] || m_rr != 1'b1);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_rr     <= 1'b1;
        end else if (!halt) begin
            if (m_active) begin
                m_t <= m_t + 1;
                if (m_t + 1 == acc_len(m_wr)) m_active <= 1'b0;
            end else if (|m_ready) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_own    <= m_ready[1];
                m_rr     <= m_ready[1];
                m_wr     <= req_write[m_ready[1]];
                m_ba     <= int'(req_ba[m_ready[1]*BAW +: BAW]);
                m_row    <= int'(req_row[m_ready[1]*AW +: AW]);
                m_col    <= int'(req_col[m_ready[1]*CW +: CW]);
            end
        end
    end

    logic [18:0] e_cmd;
    int          e_ba, e_row, e_col;
    logic [1:0]  e_done;

    always_comb begin
        e_cmd  = '0;
        e_ba   = 0;
        e_row  = 0;
        e_col  = 0;
        e_done = 2'b00;
        if (m_active) begin
            if (m_t == 0) begin
                e_cmd = CmdAct;
                e_ba  = m_ba;
                e_row = m_row;
            end else if (m_t >= T_RCD && m_t < T_RCD + BL) begin
                e_cmd = m_wr ? CmdWr : CmdRd;
                e_ba  = m_ba;
                e_row = m_row;
                e_col = (m_col + m_t - T_RCD) % (1 << CW);
            end else if (m_t == pr_off(m_wr)) begin
                e_cmd  = CmdPr;
                e_ba   = m_ba;
                e_done = m_own ? 2'b10 : 2'b01;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("commands", 32'(commands), 32'(e_cmd));
            chk("ba", 32'(ba), e_ba);
            chk("row", 32'(row), e_row);
            chk("column", 32'(column), e_col);
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(e_done));
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("cmd_legal_bits", 32'(commands & ~(CmdAct | CmdPr | CmdRd | CmdWr)), 32'd0);
            chk("cmd_onehot0", 32'($onehot0(commands)), 32'd1);
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        int id;
        bit wr;
        int ba;
        int row;
        int col;
        int halt_beat;
        int halt_len;
        int e_first;
        int e_last;
        int e_beats;
        int e_pr;
        int e_idle;
    } vec_t;

    vec_t vecs[5];

    task automatic wait_accept(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                @(posedge clk);
                #1;
                req_valid[id] = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit idle_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
        chk(nm, 32'(idle_seen), 32'd1);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        bit          ok;
        bit          halted   = 1'b0;
        int          act_n    = -1;
        int          pr_n     = -1;
        int          idle_n   = -1;
        int          beats    = 0;
        int          first    = -1;
        int          last     = -1;
        int          hcnt     = 0;
        int          act_ba   = -1;
        int          act_row  = -1;
        logic [1:0]  done_pr  = 2'b00;
        logic [18:0] beat_cmd = '0;
        string       tag;
        tag = $sformatf("vec%0d", k);
        @(posedge clk);
        #1;
        req_write[v.id]            = v.wr;
        req_ba[v.id*BAW +: BAW]    = BAW'(v.ba);
        req_row[v.id*AW +: AW]     = AW'(v.row);
        req_col[v.id*CW +: CW]     = CW'(v.col);
        req_valid[v.id]            = 1'b1;
        wait_accept(v.id, ok);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        for (int n = 0; n < 80 && idle_n < 0; n++) begin
            @(negedge clk);
            if (commands == CmdAct && act_n < 0) begin
                act_n   = n;
                act_ba  = int'(ba);
                act_row = int'(row);
            end
            if (commands == CmdRd || commands == CmdWr) begin
                if (first < 0) begin
                    first    = int'(column);
                    beat_cmd = commands;
                end
                last = int'(column);
                beats++;
            end
            if (commands == CmdPr && pr_n < 0) begin
                pr_n    = n;
                done_pr = done;
            end
            if (pr_n >= 0 && !busy) idle_n = n;
            if (idle_n < 0) begin
                @(posedge clk);
                #1;
                if (hcnt > 0) begin
                    hcnt--;
                    if (hcnt == 0) halt = 1'b0;
                end
                if (!halted && v.halt_len > 0 && beats == v.halt_beat) begin
                    halt   = 1'b1;
                    hcnt   = v.halt_len;
                    halted = 1'b1;
                end
            end
        end
        halt = 1'b0;
        chk({tag, "_act_offset"}, act_n, 0);
        chk({tag, "_act_ba"}, act_ba, v.ba);
        chk({tag, "_act_row"}, act_row, v.row);
        chk({tag, "_beat_cmd"}, 32'(beat_cmd), 32'(v.wr ? CmdWr : CmdRd));
        chk({tag, "_first_col"}, first, v.e_first);
        chk({tag, "_last_col"}, last, v.e_last);
        chk({tag, "_beats"}, beats, v.e_beats);
        chk({tag, "_pr_offset"}, pr_n, v.e_pr);
        chk({tag, "_done_at_pr"}, 32'(done_pr), 32'(v.id == 1 ? 2'b10 : 2'b01));
        chk({tag, "_idle_offset"}, idle_n, v.e_idle);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int acts;
        int act_cyc[4];
        int act_ba[4];
        int rb;
        int nz;
        bit got_burst;

        // id wr ba row col halt_beat halt_len first last beats pr idle
        vecs[0] = '{0, 1'b0, 1, 1, 1, -1, 0, 1, 8, 8, 12, 15};
        vecs[1] = '{1, 1'b1, 2, 5, 1022, -1, 0, 1022, 5, 8, 14, 17};
        vecs[2] = '{0, 1'b1, 3, 'h1FFFF, 0, -1, 0, 0, 7, 8, 14, 17};
        vecs[3] = '{1, 1'b0, 0, 100, 1020, -1, 0, 1020, 3, 8, 12, 15};
        vecs[4] = '{0, 1'b0, 2, 77, 10, 2, 3, 10, 17, 11, 15, 18};

        // Reset state
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_commands", 32'(commands), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // Round-robin alternation with both requesters continuously valid
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        req_write  = 2'b10;
        req_ba     = {2'd3, 2'd0};
        req_row    = {17'd20, 17'd10};
        req_col    = {10'd0, 10'd0};
        req_valid  = 2'b11;
        acts = 0;
        rb   = 0;
        for (int i = 0; i < 120 && acts < 4; i++) begin
            @(negedge clk);
            if (busy && req_ready != 2'b00) rb++;
            if (commands == CmdAct) begin
                act_cyc[acts] = cyc;
                act_ba[acts]  = int'(ba);
                acts++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("alt_act_count", acts, 4);
        chk("alt_owner0", act_ba[0], 0);
        chk("alt_owner1", act_ba[1], 3);
        chk("alt_owner2", act_ba[2], 0);
        chk("alt_owner3", act_ba[3], 3);
        chk("alt_space_rd", act_cyc[1] - act_cyc[0], 16);
        chk("alt_space_wr", act_cyc[2] - act_cyc[1], 18);
        chk("alt_space_rd2", act_cyc[3] - act_cyc[2], 16);
        chk("alt_ready_while_busy", rb, 0);
        wait_idle("alt_idle");

        // Asynchronous reset mid-burst
        @(posedge clk);
        #1;
        req_write[1]      = 1'b0;
        req_ba[BAW +: BAW] = 2'd1;
        req_row[AW +: AW]  = 17'd33;
        req_col[CW +: CW]  = 10'd5;
        req_valid[1]      = 1'b1;
        wait_accept(1, ok);
        chk("rst_accept", 32'(ok), 32'd1);
        got_burst = 1'b0;
        nz = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (commands == CmdRd) nz++;
            if (nz == 3) begin
                got_burst = 1'b1;
                break;
            end
        end
        chk("rst_reached_burst", 32'(got_burst), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_cmd_immediate", 32'(commands), 32'd0);
        chk("rst_busy_immediate", 32'(busy), 32'd0);
        chk("rst_col_immediate", 32'(column), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (commands != '0) nz++;
        end
        chk("rst_no_pr_after", nz, 0);
        @(posedge clk);
        #1;
        req_write     = 2'b01;
        req_ba        = {2'd1, 2'd2};
        req_row       = {17'd4, 17'd9};
        req_valid     = 2'b11;
        @(negedge clk);
        chk("rst_tie_to_req0", 32'(req_ready), 32'd1);
        wait_accept(0, ok);
        @(negedge clk);
        chk("rst_fresh_act", 32'(commands), 32'(CmdAct));
        chk("rst_fresh_ba", 32'(ba), 32'd2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle("rst_idle");

        // Randomized traffic with halts and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            halt      = ($urandom_range(0, 9) == 0);
            reset_n   = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 3) == 0) req_valid[0] = ~req_valid[0];
            if ($urandom_range(0, 3) == 0) req_valid[1] = ~req_valid[1];
            req_write = 2'($urandom);
            req_ba    = 4'($urandom);
            req_row   = 34'({$urandom, $urandom});
            req_col   = 20'($urandom);
        end
        @(posedge clk);
        #1;
        halt      = 1'b0;
        reset_n   = 1'b1;
        req_valid = 2'b00;
        wait_idle("rand_idle");

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
